// File: rtl/reaction_tester_core_if.sv
// -----------------------------------------------------------------------------
// reaction_tester_core_if
// Purpose : groups the game-control pulses, the random source and all status
//           outputs of reaction_tester_core into one bundle.
// Modports: master - key/pulse source and display side (drives the pulses,
//                    player_sel and rand_in; observes status)
//           slave  - the reaction_tester_core itself
// Signals : act_pulse, react_pulse, cmp_pulse, clr_pulse  (master -> slave)
//           player_sel[PW], rand_in[16]                   (master -> slave)
//           state[3], cur_player[PW], stimulus, react_time[TIME_W],
//           react_valid, false_start, rounds_done[LOG2_ROUNDS+1],
//           avg_time[TIME_W], best_time[TIME_W], winner[PW],
//           winner_valid, tie                             (slave -> master)
//
// Handshake: there is no ready/back-pressure. Every *_pulse input is a
// single-cycle strobe that is acted on in the cycle it is high, or dropped if
// the current state has no use for it. react_valid and false_start are
// single-cycle strobes out; every other output is a level that holds until
// the state machine changes it.
// -----------------------------------------------------------------------------
interface reaction_tester_core_if #(
  parameter int N_PLAYERS   = 2,
  parameter int LOG2_ROUNDS = 3,
  parameter int TIME_W      = 10
);
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic                   act_pulse;
  logic                   react_pulse;
  logic                   cmp_pulse;
  logic                   clr_pulse;
  logic [PW-1:0]          player_sel;
  logic [15:0]            rand_in;

  logic [2:0]             state;
  logic [PW-1:0]          cur_player;
  logic                   stimulus;
  logic [TIME_W-1:0]      react_time;
  logic                   react_valid;
  logic                   false_start;
  logic [LOG2_ROUNDS:0]   rounds_done;
  logic [TIME_W-1:0]      avg_time;
  logic [TIME_W-1:0]      best_time;
  logic [PW-1:0]          winner;
  logic                   winner_valid;
  logic                   tie;

  modport master (
    output act_pulse, react_pulse, cmp_pulse, clr_pulse, player_sel, rand_in,
    input  state, cur_player, stimulus, react_time, react_valid, false_start,
           rounds_done, avg_time, best_time, winner, winner_valid, tie
  );

  modport slave (
    input  act_pulse, react_pulse, cmp_pulse, clr_pulse, player_sel, rand_in,
    output state, cur_player, stimulus, react_time, react_valid, false_start,
           rounds_done, avg_time, best_time, winner, winner_valid, tie
  );
endinterface

// File: rtl/reaction_tester_core.sv
// -----------------------------------------------------------------------------
// reaction_tester_core
// Purpose : reaction-time game controller for N_PLAYERS players, each playing
//           2^LOG2_ROUNDS rounds. Contains the ms prescaler, random-delay wait,
//           reaction timer with timeout, false-start detection, per-player
//           sum/best/average and a sequential lowest-sum winner scan.
// Ports   : clk   - system clock
//           rstn  - asynchronous active-low reset
//           bus   - reaction_tester_core_if.slave (pulses, player select,
//                   random input, state and all result outputs)
// -----------------------------------------------------------------------------
module reaction_tester_core #(
  parameter int N_PLAYERS   = 2,
  parameter int LOG2_ROUNDS = 3,
  parameter int CLK_PER_MS  = 12000,
  parameter int DELAY_MIN   = 1000,
  parameter int DELAY_MAX   = 9999,
  parameter int TIMEOUT_MS  = 999,
  parameter int TIME_W      = 10
) (
  input logic                   clk,
  input logic                   rstn,
  reaction_tester_core_if.slave bus
);
  localparam int PW        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int SUM_W     = TIME_W + LOG2_ROUNDS;
  localparam int RND_W     = LOG2_ROUNDS + 1;
  localparam int PS_W      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int DLY_W     = $clog2(DELAY_MAX + 1);
  localparam int DLY_RANGE = DELAY_MAX - DELAY_MIN + 1;

  localparam logic [RND_W-1:0]  ROUNDS_FULL = RND_W'(2 ** LOG2_ROUNDS);
  localparam logic [TIME_W-1:0] TMO         = TIME_W'(TIMEOUT_MS);
  localparam logic [PS_W-1:0]   PS_LAST     = PS_W'(CLK_PER_MS - 1);
  localparam logic [PW-1:0]     LAST_PLAYER = PW'(N_PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_START   = 3'd2,
    S_STORE   = 3'd3,
    S_FOUL    = 3'd4,
    S_DONE    = 3'd5,
    S_COMPARE = 3'd6
  } state_t;

  state_t             r_state;
  logic [PW-1:0]      r_cur;
  logic [PS_W-1:0]    r_presc;
  logic [DLY_W-1:0]   r_delay_left;
  logic [TIME_W-1:0]  r_rt;
  logic               r_stimulus;
  logic               r_react_valid;
  logic               r_false_start;
  logic [SUM_W-1:0]   r_sum    [N_PLAYERS];
  logic [TIME_W-1:0]  r_best   [N_PLAYERS];
  logic [RND_W-1:0]   r_rounds [N_PLAYERS];
  logic [PW-1:0]      r_scan;
  logic [SUM_W-1:0]   r_scan_sum;
  logic [PW-1:0]      r_winner;
  logic               r_winner_valid;
  logic               r_tie;

  logic               w_tick;
  logic [DLY_W-1:0]   w_delay;
  logic               w_sel_ok;
  logic               w_sel_open;
  logic               w_all_done;
  logic               w_go_wait;
  logic [TIME_W-1:0]  w_rt_inc;
  logic [TIME_W-1:0]  w_rt_next;

  assign w_tick     = (r_presc == PS_LAST);
  assign w_delay    = DLY_W'(DELAY_MIN) + DLY_W'(bus.rand_in % 16'(DLY_RANGE));
  assign w_sel_ok   = (32'(bus.player_sel) < 32'(N_PLAYERS));
  // A selected player may start a round only while it still has rounds left.
  assign w_sel_open = w_sel_ok && (r_rounds[bus.player_sel] != ROUNDS_FULL);

  // Every state that can start a new round funnels through this one condition.
  assign w_go_wait  = bus.act_pulse && w_sel_open &&
                      ((r_state == S_IDLE) || (r_state == S_FOUL) ||
                       (r_state == S_DONE) ||
                       ((r_state == S_STORE) && (r_rounds[r_cur] != ROUNDS_FULL)));

  // A tick landing in the same cycle as the reaction is counted, so a react on
  // the saturating tick records TIMEOUT_MS.
  assign w_rt_inc   = (r_rt >= TMO) ? TMO : r_rt + 1'b1;
  assign w_rt_next  = w_tick ? w_rt_inc : r_rt;

  always_comb begin
    w_all_done = 1'b1;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (r_rounds[i] != ROUNDS_FULL) w_all_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_cur          <= '0;
      r_presc        <= '0;
      r_delay_left   <= '0;
      r_rt           <= '0;
      r_stimulus     <= 1'b0;
      r_react_valid  <= 1'b0;
      r_false_start  <= 1'b0;
      r_scan         <= '0;
      r_scan_sum     <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      r_tie          <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        r_sum[i]    <= '0;
        r_best[i]   <= '1;
        r_rounds[i] <= '0;
      end
    end else begin
      r_react_valid <= 1'b0;
      r_false_start <= 1'b0;
      // Free-running between entries; only its phase after WAIT/START entry matters.
      r_presc       <= w_tick ? '0 : r_presc + 1'b1;

      if (bus.clr_pulse) begin
        r_state        <= S_IDLE;
        r_stimulus     <= 1'b0;
        r_winner_valid <= 1'b0;
        r_tie          <= 1'b0;
      end else if (w_go_wait) begin
        r_state      <= S_WAIT;
        r_cur        <= bus.player_sel;
        r_presc      <= '0;
        r_delay_left <= w_delay;
      end else begin
        case (r_state)
          S_WAIT: begin
            if (bus.react_pulse) begin
              r_state       <= S_FOUL;
              r_false_start <= 1'b1;
            end else if (w_tick) begin
              if (r_delay_left <= DLY_W'(1)) begin
                r_state    <= S_START;
                r_presc    <= '0;
                r_rt       <= '0;
                r_stimulus <= 1'b1;
              end else begin
                r_delay_left <= r_delay_left - 1'b1;
              end
            end
          end
          S_START: begin
            r_rt <= w_rt_next;
            if (bus.react_pulse || (w_rt_next == TMO)) begin
              r_state         <= S_STORE;
              r_stimulus      <= 1'b0;
              r_react_valid   <= 1'b1;
              r_sum[r_cur]    <= r_sum[r_cur] + SUM_W'(w_rt_next);
              r_rounds[r_cur] <= r_rounds[r_cur] + 1'b1;
              if (w_rt_next < r_best[r_cur]) r_best[r_cur] <= w_rt_next;
            end
          end
          S_STORE: begin
            if (bus.act_pulse && (r_rounds[r_cur] == ROUNDS_FULL)) r_state <= S_DONE;
          end
          S_DONE: begin
            if (bus.cmp_pulse && w_all_done) begin
              r_state        <= S_COMPARE;
              r_scan         <= '0;
              r_winner_valid <= 1'b0;
              r_tie          <= 1'b0;
            end
          end
          S_COMPARE: begin
            if (!r_winner_valid) begin
              // Player 0 seeds the running minimum; strict < keeps the lowest index.
              if ((r_scan == '0) || (r_sum[r_scan] < r_scan_sum)) begin
                r_scan_sum <= r_sum[r_scan];
                r_winner   <= r_scan;
                r_tie      <= 1'b0;
              end else if (r_sum[r_scan] == r_scan_sum) begin
                r_tie <= 1'b1;
              end
              if (r_scan == LAST_PLAYER) r_winner_valid <= 1'b1;
              else                       r_scan         <= r_scan + 1'b1;
            end
          end
          S_IDLE, S_FOUL: ;
          default: r_state <= S_IDLE;
        endcase
      end

      // Statistics are wiped on the clear edge itself so IDLE never shows stale data.
      if (bus.clr_pulse || (r_state == S_IDLE)) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          r_sum[i]    <= '0;
          r_best[i]   <= '1;
          r_rounds[i] <= '0;
        end
      end
    end
  end

  assign bus.state        = r_state;
  assign bus.cur_player   = r_cur;
  assign bus.stimulus     = r_stimulus;
  assign bus.react_time   = r_rt;
  assign bus.react_valid  = r_react_valid;
  assign bus.false_start  = r_false_start;
  assign bus.rounds_done  = r_rounds[r_cur];
  assign bus.avg_time     = TIME_W'(r_sum[r_cur] >> LOG2_ROUNDS);
  assign bus.best_time    = r_best[r_cur];
  assign bus.winner       = r_winner;
  assign bus.winner_valid = r_winner_valid;
  assign bus.tie          = r_tie & r_winner_valid;

endmodule
